// File: rtl/microseq_datapath_if.sv
// Command handshake and memory bus bundle for the micro-sequenced datapath.
// The datapath connects through the slave modport; the command/memory side uses master.
interface microseq_datapath_if #(
  parameter int WIDTH = 32,
  parameter int RW    = 4,
  parameter int AW    = 9
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [RW-1:0]    cmd_ra;
  logic [RW-1:0]    cmd_rb;
  logic [RW-1:0]    cmd_rc;
  logic [WIDTH-1:0] cmd_imm;
  logic [AW-1:0]    mem_addr;
  logic             mem_re;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_imm, mem_rdata, mem_ack,
    input  cmd_ready, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_imm, mem_rdata, mem_ack,
    output cmd_ready, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/microseq_datapath.sv
// Single-bus micro-sequenced datapath: register file, Y/Z/HI/LO/MAR/MDR and a
// multi-cycle FSM executing ALU, multiply, HI/LO moves and timed memory accesses.
module microseq_datapath #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int AW      = 9,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             clr,
  microseq_datapath_if.slave io,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] bus_out
);
  localparam int RW = $clog2(NREGS);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, T_Y, T_Z, T_MAR, T_MEM, T_WB} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB, OP_AND, OP_OR, OP_ADDI,
    OP_LD, OP_ST, OP_MUL, OP_MFHI, OP_MFLO
  } op_t;

  state_t                   state, state_nx;
  op_t                      op_q;
  logic [RW-1:0]            ra_q, rb_q, rc_q;
  logic [WIDTH-1:0]         imm_q, y, mdr, hi, lo;
  logic [AW-1:0]            mar;
  logic [2*WIDTH-1:0]       z, z_nx;
  logic [WIDTH-1:0]         regs [NREGS];
  logic [CW-1:0]            wait_cnt;

  logic                     is_mem, legal, timeout;
  logic [WIDTH-1:0]         base_b, op2, alu_lo;
  logic signed [2*WIDTH-1:0] y_ext, op2_ext, mul_p;

  assign legal         = (io.cmd_op <= 4'd9);
  assign io.cmd_ready  = (state == IDLE);
  assign busy          = (state != IDLE);
  assign io.mem_addr   = mar;
  assign io.mem_re     = (state == T_MEM) && (op_q == OP_LD);
  assign io.mem_we     = (state == T_MEM) && (op_q == OP_ST);
  assign io.mem_wdata  = io.mem_we ? regs[ra_q] : '0;
  assign hi_out        = hi;
  assign lo_out        = lo;

  always_comb begin
    is_mem   = (op_q == OP_LD) || (op_q == OP_ST);
    base_b   = (rb_q == '0 && (op_q == OP_ADDI || is_mem)) ? '0 : regs[rb_q];
    op2      = regs[rc_q];
    alu_lo   = op2;
    y_ext    = {{WIDTH{y[WIDTH-1]}}, y};
    op2_ext  = '0;
    mul_p    = '0;
    z_nx     = '0;
    timeout  = 1'b0;
    state_nx = state;
    bus_out  = '0;

    case (op_q)
      OP_ADDI, OP_LD, OP_ST: op2 = imm_q;
      OP_MFHI:               op2 = hi;
      OP_MFLO:               op2 = lo;
      default:               op2 = regs[rc_q];
    endcase

    case (op_q)
      OP_ADD, OP_ADDI, OP_LD, OP_ST: alu_lo = y + op2;
      OP_SUB:                        alu_lo = y - op2;
      OP_AND:                        alu_lo = y & op2;
      OP_OR:                         alu_lo = y | op2;
      default:                       alu_lo = op2;
    endcase

    // Both operands sign-extended to full width so the low 2*WIDTH product bits are the signed result
    op2_ext = {{WIDTH{op2[WIDTH-1]}}, op2};
    mul_p   = y_ext * op2_ext;
    z_nx    = (op_q == OP_MUL) ? mul_p : {{WIDTH{1'b0}}, alu_lo};
    timeout = !io.mem_ack && (wait_cnt == CW'(TIMEOUT - 1));

    case (state)
      IDLE:    if (io.cmd_valid && legal) state_nx = T_Y;
      T_Y:     state_nx = T_Z;
      T_Z:     state_nx = is_mem ? T_MAR : T_WB;
      T_MAR:   state_nx = T_MEM;
      T_MEM: begin
        if (io.mem_ack)   state_nx = (op_q == OP_LD) ? T_WB : IDLE;
        else if (timeout) state_nx = IDLE;
      end
      T_WB:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    case (state)
      T_Y:          bus_out = base_b;
      T_Z:          bus_out = op2;
      T_MAR, T_WB:  bus_out = z[WIDTH-1:0];
      default:      bus_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      op_q     <= OP_ADD;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      imm_q    <= '0;
      y        <= '0;
      z        <= '0;
      mar      <= '0;
      mdr      <= '0;
      hi       <= '0;
      lo       <= '0;
      wait_cnt <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (io.cmd_valid && legal) begin
            op_q  <= op_t'(io.cmd_op);
            ra_q  <= io.cmd_ra;
            rb_q  <= io.cmd_rb;
            rc_q  <= io.cmd_rc;
            imm_q <= io.cmd_imm;
          end else if (io.cmd_valid) begin
            err <= 1'b1;
          end
        end
        T_Y:   y <= base_b;
        T_Z:   z <= z_nx;
        T_MAR: begin
          mar      <= z[AW-1:0];
          wait_cnt <= '0;
        end
        T_MEM: begin
          if (io.mem_ack) begin
            if (op_q == OP_LD) mdr  <= io.mem_rdata;
            else               done <= 1'b1;
          end else if (timeout) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        T_WB: begin
          done <= 1'b1;
          if (op_q == OP_MUL) begin
            hi <= z[2*WIDTH-1:WIDTH];
            lo <= z[WIDTH-1:0];
          end else if (op_q == OP_LD) begin
            regs[ra_q] <= mdr;
          end else begin
            regs[ra_q] <= z[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_microseq_datapath.sv
// Directed bench for microseq_datapath: an instruction-level model tracks registers
// and expected cycle timing; a compare process checks every DUT output each cycle.
module tb_microseq_datapath;
  localparam int W = 32, NR = 16, RW = 4, AW = 9, TO = 255;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  microseq_datapath_if #(.WIDTH(W), .RW(RW), .AW(AW)) io ();
  logic         done, err, busy;
  logic [W-1:0] hi_out, lo_out, bus_out;

  microseq_datapath #(.WIDTH(W), .NREGS(NR), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .io(io), .done(done), .err(err), .busy(busy),
    .hi_out(hi_out), .lo_out(lo_out), .bus_out(bus_out)
  );

  int n_chk = 0, n_fail = 0;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // memory side: ack timing knobs, read data derived from the address
  int  ack_delay = 0, mem_cyc = 0;
  bit  ack_never = 0, ack_stuck = 0, manual_ack = 0;
  always @(negedge clk) begin
    io.mem_rdata = 32'hC0DE_0000 | W'(io.mem_addr);
    if (!manual_ack) begin
      if (io.mem_re || io.mem_we) begin
        io.mem_ack = (!ack_never && mem_cyc >= ack_delay) || ack_stuck;
        mem_cyc++;
      end else begin
        mem_cyc = 0;
        io.mem_ack = ack_stuck;
      end
    end
  end

  // instruction-level model: stage 0 idle, 1 operand/ALU steps, 2 memory wait, 3 load write-back
  logic [W-1:0]  m_r [NR];
  logic [W-1:0]  m_hi, m_lo, m_b, m_op2, m_imm, m_mdr, m_t;
  logic [63:0]   m_z;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_op;
  int            m_ra, m_rb, m_rc, stage = 0, cnt = 0, wcnt = 0, wr_count = 0;
  bit            m_done = 0, m_err = 0, chk_en = 0;
  longint        sa, sb;

  always @(posedge clk) begin
    if (io.mem_we && io.mem_ack && !clr) wr_count++;
    m_done = 0;
    m_err  = 0;
    if (clr) begin
      for (int i = 0; i < NR; i++) m_r[i] = '0;
      m_hi = '0; m_lo = '0; stage = 0; m_op = '0; m_ra = 0;
    end else begin
      case (stage)
        0: if (io.cmd_valid) begin
          if (io.cmd_op > 4'd9) m_err = 1;
          else begin
            m_op = io.cmd_op; m_ra = int'(io.cmd_ra); m_rb = int'(io.cmd_rb);
            m_rc = int'(io.cmd_rc); m_imm = io.cmd_imm;
            m_b   = (m_op inside {4, 5, 6} && m_rb == 0) ? '0 : m_r[m_rb];
            m_op2 = (m_op inside {4, 5, 6}) ? m_imm : (m_op == 8) ? m_hi :
                    (m_op == 9) ? m_lo : m_r[m_rc];
            case (m_op)
              0, 4, 5, 6: m_t = m_b + m_op2;
              1:          m_t = m_b - m_op2;
              2:          m_t = m_b & m_op2;
              3:          m_t = m_b | m_op2;
              default:    m_t = m_op2;
            endcase
            m_z = {32'h0, m_t};
            if (m_op == 7) begin
              sa = $signed(m_b); sb = $signed(m_op2);
              m_z = sa * sb;
            end
            stage = 1; cnt = 1;
          end
        end
        1: if (cnt < 3) cnt++;
           else if (m_op inside {5, 6}) begin
             stage = 2; wcnt = 0; m_addr = m_z[AW-1:0];
           end else begin
             if (m_op == 7) {m_hi, m_lo} = m_z;
             else           m_r[m_ra] = m_z[W-1:0];
             stage = 0; m_done = 1;
           end
        2: if (io.mem_ack) begin
             if (m_op == 5) begin m_mdr = io.mem_rdata; stage = 3; end
             else begin stage = 0; m_done = 1; end
           end else begin
             wcnt++;
             if (wcnt == TO) begin stage = 0; m_err = 1; end
           end
        default: begin m_r[m_ra] = m_mdr; stage = 0; m_done = 1; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", io.cmd_ready, stage == 0);
      chk("busy", busy, stage != 0);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("mem_re", io.mem_re, stage == 2 && m_op == 5);
      chk("mem_we", io.mem_we, stage == 2 && m_op == 6);
      chk("mem_wdata", io.mem_wdata, (stage == 2 && m_op == 6) ? m_r[m_ra] : '0);
      if (stage == 2) chk("mem_addr", io.mem_addr, m_addr);
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
      case (stage)
        1:       chk("bus_out", bus_out, cnt == 1 ? m_b : cnt == 2 ? m_op2 : m_z[W-1:0]);
        3:       chk("bus_out", bus_out, m_z[W-1:0]);
        default: chk("bus_out", bus_out, '0);
      endcase
    end
  end

  int           lat, rlow, wecyc, recyc, wr0;
  bit           gerr;
  logic [W-1:0] wd;
  logic [AW-1:0] wa;

  task automatic do_cmd(input logic [3:0] op, input int ra, input int rb, input int rc,
                        input logic [W-1:0] imm, input bit poke);
    lat = 0; rlow = 0; gerr = 0; wecyc = 0; recyc = 0; wd = '0; wa = '0;
    @(negedge clk);
    io.cmd_valid = 1'b1; io.cmd_op = op; io.cmd_ra = RW'(ra); io.cmd_rb = RW'(rb);
    io.cmd_rc = RW'(rc); io.cmd_imm = imm;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) begin
        io.cmd_valid = poke && (op <= 4'd9);
        io.cmd_op = 4'd1; io.cmd_ra = '1; io.cmd_rb = '1; io.cmd_rc = '1; io.cmd_imm = ~imm;
      end
      if (n == 2) io.cmd_valid = 1'b0;
      if (!io.cmd_ready) rlow++;
      if (io.mem_we) begin wecyc++; wd = io.mem_wdata; wa = io.mem_addr; end
      if (io.mem_re) begin recyc++; wa = io.mem_addr; end
      if (done || err) begin lat = n; gerr = err; break; end
    end
    io.cmd_valid = 1'b0;
    chk("cmd_completes", lat > 0, 1);
  endtask

  task automatic dump_regs();
    for (int i = 0; i < NR; i++) do_cmd(4'd6, i, 0, 0, W'(32'h100 + i), 0);
  endtask

  initial begin
    io.cmd_valid = 0; io.cmd_op = 0; io.cmd_ra = 0; io.cmd_rb = 0; io.cmd_rc = 0;
    io.cmd_imm = 0; io.mem_ack = 0; io.mem_rdata = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_ready", io.cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_hi", hi_out, 0);
    clr = 0;

    do_cmd(4'd4, 1, 0, 0, 32'd5, 1);
    chk("addi_lat", lat, 4); chk("addi_ready_low", rlow, 3);
    do_cmd(4'd0, 2, 1, 1, 32'd0, 1);
    chk("add_lat", lat, 4); chk("add_ready_low", rlow, 3);
    do_cmd(4'd6, 2, 0, 0, 32'h40, 0);
    chk("st_r2_val", wd, 32'd10); chk("st_r2_addr", wa, 9'h040); chk("st_lat", lat, 5);

    do_cmd(4'd4, 3, 0, 0, 32'h7FFF_FFFF, 0);
    do_cmd(4'd7, 7, 3, 3, 32'd0, 1);
    chk("mul_hi", hi_out, 32'h3FFF_FFFF); chk("mul_lo", lo_out, 32'h1);
    do_cmd(4'd9, 4, 0, 0, 32'd0, 0);
    do_cmd(4'd6, 4, 0, 0, 32'h44, 0);
    chk("mflo_r4", wd, 32'h1);
    do_cmd(4'd6, 7, 0, 0, 32'h48, 0);
    chk("mul_no_gpr_write", wd, 32'h0);

    do_cmd(4'd4, 5, 0, 0, 32'h1F0, 0);
    do_cmd(4'd4, 6, 0, 0, 32'h1234_5678, 0);
    ack_delay = 2; wr0 = wr_count;
    do_cmd(4'd6, 6, 5, 0, 32'h20, 1);
    chk("st_trunc_addr", wa, 9'h010); chk("st_we_cycles", wecyc, 3);
    chk("st_wdata", wd, 32'h1234_5678); chk("st_one_write", wr_count - wr0, 1);
    chk("st_delay_lat", lat, 7);
    ack_delay = 0; ack_stuck = 1; wr0 = wr_count;
    do_cmd(4'd6, 1, 0, 0, 32'h1FF, 0);
    chk("st_stuck_one_write", wr_count - wr0, 1); chk("st_stuck_we", wecyc, 1);
    ack_stuck = 0;

    do_cmd(4'd5, 8, 5, 0, 32'd0, 1);
    chk("ld_lat", lat, 6); chk("ld_addr", wa, 9'h1F0);
    do_cmd(4'd6, 8, 0, 0, 32'h50, 0);
    chk("ld_r8", wd, 32'hC0DE_01F0);

    ack_never = 1;
    do_cmd(4'd5, 6, 0, 0, 32'd3, 0);
    chk("ld_to_err", gerr, 1); chk("ld_to_waits", recyc, 255); chk("ld_to_lat", lat, 259);
    ack_never = 0;
    do_cmd(4'd6, 6, 0, 0, 32'h54, 0);
    chk("ld_to_r6_kept", wd, 32'h1234_5678);
    do_cmd(4'd12, 9, 1, 2, 32'd0, 0);
    chk("illegal_err", gerr, 1); chk("illegal_lat", lat, 1);

    do_cmd(4'd0, 2, 2, 1, 32'd0, 0);
    do_cmd(4'd1, 9, 1, 2, 32'd0, 0);
    do_cmd(4'd2, 10, 6, 8, 32'd0, 0);
    do_cmd(4'd3, 11, 6, 9, 32'd0, 0);
    do_cmd(4'd8, 12, 0, 0, 32'd0, 0);
    do_cmd(4'd4, 0, 0, 0, 32'd7, 0);
    do_cmd(4'd0, 13, 0, 0, 32'd0, 0);
    do_cmd(4'd4, 14, 0, 0, 32'd1, 0);
    do_cmd(4'd7, 15, 9, 1, 32'd0, 0);
    do_cmd(4'd8, 15, 0, 0, 32'd0, 0);
    do_cmd(4'd6, 9, 0, 0, 32'h58, 0);
    chk("sub_r9", wd, 32'hFFFF_FFF6);
    do_cmd(4'd6, 13, 0, 0, 32'h5C, 0);
    chk("r0_reads_normal", wd, 32'd14);
    dump_regs();

    manual_ack = 1; io.mem_ack = 0;
    @(negedge clk);
    io.cmd_valid = 1; io.cmd_op = 4'd5; io.cmd_ra = 4'd9; io.cmd_rb = 4'd5; io.cmd_imm = 0;
    @(negedge clk);
    io.cmd_valid = 0;
    for (int n = 0; n < 10 && !io.mem_re; n++) @(negedge clk);
    chk("clr_reach_mem", io.mem_re, 1);
    io.mem_ack = 1; clr = 1;
    @(negedge clk);
    clr = 0; io.mem_ack = 0; manual_ack = 0;
    chk("clr_ready", io.cmd_ready, 1); chk("clr_no_done", done, 0);
    chk("clr_hi", hi_out, 0); chk("clr_re", io.mem_re, 0);
    repeat (4) @(negedge clk);
    do_cmd(4'd6, 1, 0, 0, 32'h60, 0);
    chk("clr_r1_zero", wd, 32'h0);
    dump_regs();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/microseq_datapath.md
MICROSEQ_DATAPATH -- requirements
Module: microseq_datapath

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the register, bus and ALU operand width.
REQ-002 The block SHALL have parameter NREGS, default 16, meaning the general register count, a power of two of at least 4; RW = log2(NREGS).
REQ-003 The block SHALL have parameter AW, default 9, meaning the memory address width.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum memory wait in cycles before abort.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port clr, input, 1 bit, a synchronous active-high reset.
REQ-007 The block SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1) forming the command handshake.
REQ-008 The block SHALL have command inputs cmd_op (4 bits), cmd_ra, cmd_rb and cmd_rc (RW bits each) and cmd_imm (WIDTH bits).
REQ-009 The block SHALL have output mem_addr, AW bits, plus outputs mem_re, mem_we and mem_wdata (WIDTH bits).
REQ-010 The block SHALL have inputs mem_rdata (WIDTH bits) and mem_ack (1 bit).
REQ-011 The block SHALL have outputs done (1), err (1), busy (1), hi_out (WIDTH), lo_out (WIDTH) and bus_out (WIDTH), where bus_out is the current internal bus value.

Function
REQ-012 A command SHALL be accepted on a clock edge where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL equal (state==IDLE), and busy SHALL equal its inverse.
REQ-013 The opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LD, 6 ST, 7 MUL, 8 MFHI, 9 MFLO; codes 10-15 are illegal.
REQ-014 On acceptance, the block SHALL latch op, ra, rb, rc and imm into internal registers, and later changes to the cmd_* inputs SHALL have no effect.
REQ-015 The FSM SHALL have the states IDLE, T_Y, T_Z, T_MAR, T_MEM, T_WB.
REQ-016 For ALU-class ops (0-4, 7-9) the sequence SHALL be IDLE, T_Y, T_Z, T_WB, IDLE, with one cycle per state.
REQ-017 In T_Y, Y SHALL be loaded with the base operand B = (rb==0 and op in {ADDI, LD, ST}) ? 0 : R[rb].
REQ-018 In T_Z, Z (2*WIDTH bits) SHALL be loaded as follows.
- ADD: Y+R[rc]; SUB: Y-R[rc]; AND and OR likewise; ADDI, LD, ST: Y+imm.
- All of these wrap modulo 2^WIDTH, with the upper half of Z set to 0.
- MUL: signed Y*R[rc], full 2*WIDTH bits.
- MFHI: {0,HI}; MFLO: {0,LO}.
REQ-019 In T_WB, R[ra] SHALL be loaded with Z[WIDTH-1:0] (or with MDR for LD); for MUL, HI SHALL be loaded with Z[2W-1:W] and LO with Z[W-1:0], and no general register changes.
REQ-020 Writes to R0 SHALL be stored normally; R0 reads as 0 only in the base position of ADDI, LD and ST.
REQ-021 For LD and ST the sequence SHALL be IDLE, T_Y, T_Z, T_MAR, T_MEM, then T_WB (LD) or IDLE (ST).
REQ-022 In T_MAR, MAR SHALL be loaded with Z[AW-1:0]; the upper address bits are discarded.
REQ-023 In T_MEM, mem_addr SHALL equal MAR; mem_re (LD) or mem_we (ST) SHALL be held at 1 through the cycle in which mem_ack=1, inclusive, and SHALL be 0 in every other state.
REQ-024 mem_wdata SHALL equal R[ra] during ST T_MEM and 0 otherwise.
REQ-025 For LD, MDR SHALL be loaded with mem_rdata on the T_MEM edge where mem_ack=1.
REQ-026 A wait counter SHALL clear on entry to T_MEM and increment each T_MEM cycle without ack.
REQ-027 If the wait counter reaches TIMEOUT with no ack, the block SHALL go to IDLE, pulse err, leave no register written and not pulse done.
REQ-028 Each ST access SHALL perform exactly one memory write, even if mem_ack stays high.
REQ-029 done SHALL be a registered one-cycle pulse in the first IDLE cycle after a successful command.
- ALU-class latency: done is high exactly 4 cycles after the acceptance edge.
- With a same-cycle ack, LD done is high at 6 cycles and ST done at 5 cycles.
REQ-030 An illegal opcode SHALL be accepted, SHALL pulse err in the next cycle, SHALL remain in IDLE, and SHALL change no state.
REQ-031 cmd_valid while busy SHALL be ignored; the command is not queued.
REQ-032 When ra==rb or ra==rc, operands SHALL use pre-write values.
REQ-033 hi_out and lo_out SHALL continuously reflect HI and LO.
REQ-034 bus_out SHALL show the value driven onto the internal bus in each state: B in T_Y, the second operand in T_Z, Zlow in T_MAR and T_WB, and 0 in IDLE and T_MEM.

Reset
REQ-035 When clr=1 at a rising edge, regardless of state, the block SHALL reset the following.
- R0..R(NREGS-1), HI, LO, Y, Z, MAR, MDR and the wait counter go to 0.
- The state goes to IDLE.
REQ-036 In the cycle following a reset edge, done, err, mem_re and mem_we SHALL be 0, and cmd_ready SHALL be 1.
REQ-037 A reset mid-operation SHALL abort the command with no write-back and no done; a memory strobe SHALL be dropped even if mem_ack is asserted in the same cycle.

Verification
REQ-038 ADDI r1,r0,5 then ADD r2,r1,r1 SHALL give r2=10, with done 4 cycles after each acceptance and cmd_ready low for 3 cycles.
REQ-039 With r3=0x7FFFFFFF, MUL rb=r3,rc=r3 SHALL give HI=0x3FFFFFFF and LO=0x00000001, with general registers unchanged; MFLO r4 SHALL then give r4=1.
REQ-040 With r5=0x1F0 and imm=0x20, ST ra=r6,rb=r5 SHALL drive mem_addr=0x010 (truncated to AW=9) with mem_we held for 3 cycles when mem_ack is delayed by 2 cycles, and SHALL issue exactly one write.
REQ-041 LD with mem_ack never asserted SHALL pulse err after 255 wait cycles, leave R[ra] unchanged and not pulse done; an illegal op=12 SHALL pulse err the next cycle.
REQ-042 Asserting clr during LD T_MEM together with mem_ack=1 SHALL leave all registers at 0, state IDLE, and no done pulse.
